// File: rtl/led_pattern_ctrl_pkg.sv
// Shared definitions for the LED pattern controller: mode encodings,
// BOUNCE pattern constants, per-mode idx wrap limits and pattern decode.
package led_pattern_ctrl_pkg;

   localparam int unsigned IDX_W = 4;
   localparam int unsigned LED_W = 4;

   typedef enum logic [1:0] {
      MODE_BLINK  = 2'b00,
      MODE_CHASE  = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_BINARY = 2'b11
   } mode_t;

   localparam logic [LED_W-1:0] BOUNCE_P0 = 4'b0001;
   localparam logic [LED_W-1:0] BOUNCE_P1 = 4'b0010;
   localparam logic [LED_W-1:0] BOUNCE_P2 = 4'b0100;
   localparam logic [LED_W-1:0] BOUNCE_P3 = 4'b1000;
   localparam logic [LED_W-1:0] BOUNCE_P4 = 4'b0100;
   localparam logic [LED_W-1:0] BOUNCE_P5 = 4'b0010;

   localparam logic [IDX_W-1:0] IDX_MAX_BLINK  = 4'd1;
   localparam logic [IDX_W-1:0] IDX_MAX_CHASE  = 4'd3;
   localparam logic [IDX_W-1:0] IDX_MAX_BOUNCE = 4'd5;
   localparam logic [IDX_W-1:0] IDX_MAX_BINARY = 4'd15;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_BLINK:  return MODE_CHASE;
         MODE_CHASE:  return MODE_BOUNCE;
         MODE_BOUNCE: return MODE_BINARY;
         default:     return MODE_BLINK;
      endcase
   endfunction

   function automatic logic [IDX_W-1:0] idx_max(input mode_t m);
      case (m)
         MODE_BLINK:  return IDX_MAX_BLINK;
         MODE_CHASE:  return IDX_MAX_CHASE;
         MODE_BOUNCE: return IDX_MAX_BOUNCE;
         default:     return IDX_MAX_BINARY;
      endcase
   endfunction

   function automatic logic [LED_W-1:0] pattern(input mode_t m, input logic [IDX_W-1:0] idx);
      case (m)
         MODE_BLINK:  return (idx == 4'd0) ? 4'b0000 : 4'b1111;
         MODE_CHASE:  return 4'b0001 << idx;
         MODE_BOUNCE: begin
            case (idx)
               4'd0:    return BOUNCE_P0;
               4'd1:    return BOUNCE_P1;
               4'd2:    return BOUNCE_P2;
               4'd3:    return BOUNCE_P3;
               4'd4:    return BOUNCE_P4;
               4'd5:    return BOUNCE_P5;
               default: return BOUNCE_P0;
            endcase
         end
         default:     return idx;
      endcase
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_key_debounce.sv
// Push-button front end: 2-flop synchronizer, stability debouncer and a
// single-cycle press pulse on the accepted release-to-press transition.
module key_debounce
   import led_pattern_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYC = 32'd1_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_n,
   output logic press
);

   localparam int unsigned     CNT_W    = cnt_w(DEB_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_key_st;
   logic [CNT_W-1:0] r_deb_cnt;

   logic             w_differ;
   logic             w_accept;
   logic             w_key_st_nxt;
   logic [CNT_W-1:0] w_deb_cnt_nxt;

   assign w_differ = (r_sync2 != r_key_st);
   assign w_accept = w_differ && (r_deb_cnt == CNT_LAST);

   // Press fires in the same cycle the new low level is accepted.
   assign press = w_accept & ~r_sync2;

   always_comb begin
      w_key_st_nxt  = r_key_st;
      w_deb_cnt_nxt = '0;
      if (w_accept) begin
         w_key_st_nxt = r_sync2;
      end else if (w_differ) begin
         w_deb_cnt_nxt = r_deb_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_key_st  <= 1'b1;
         r_deb_cnt <= '0;
      end else begin
         r_sync1   <= key_n;
         r_sync2   <= r_sync1;
         r_key_st  <= w_key_st_nxt;
         r_deb_cnt <= w_deb_cnt_nxt;
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Four-mode LED pattern scheduler: button-driven mode FSM, prescaled step
// tick, per-mode step index and registered pattern decode.
module led_pattern_ctrl
   import led_pattern_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 32'd50_000_000,
   parameter int unsigned STEP_HZ  = 32'd4,
   parameter int unsigned DEB_CYC  = 32'd1_000_000
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             key_n,
   input  logic             en,
   output logic [LED_W-1:0] led_out,
   output logic [1:0]       mode
);

   localparam int unsigned      STEP_DIV = CLK_FREQ / ((STEP_HZ == 0) ? 1 : STEP_HZ);
   localparam int unsigned      STEP_CYC = (STEP_DIV == 0) ? 1 : STEP_DIV;
   localparam int unsigned      PRE_W    = cnt_w(STEP_CYC);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_CYC - 1);

   mode_t            r_mode;
   logic [IDX_W-1:0] r_idx;
   logic [PRE_W-1:0] r_pre_cnt;
   logic [LED_W-1:0] r_led;

   mode_t            w_mode_nxt;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [PRE_W-1:0] w_pre_nxt;
   logic             w_press;
   logic             w_step_tick;

   key_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_key_debounce (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_n     (key_n),
      .press     (w_press)
   );

   assign w_step_tick = en && (r_pre_cnt == PRE_LAST);

   // A mode change restarts the new pattern from idx 0 and drops any tick.
   always_comb begin
      w_mode_nxt = r_mode;
      w_idx_nxt  = r_idx;
      w_pre_nxt  = r_pre_cnt;
      if (w_press) begin
         w_mode_nxt = next_mode(r_mode);
         w_idx_nxt  = '0;
         w_pre_nxt  = '0;
      end else if (w_step_tick) begin
         w_pre_nxt = '0;
         w_idx_nxt = (r_idx == idx_max(r_mode)) ? '0 : r_idx + IDX_W'(1);
      end else if (en) begin
         w_pre_nxt = r_pre_cnt + PRE_W'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_mode    <= MODE_BLINK;
         r_idx     <= '0;
         r_pre_cnt <= '0;
         r_led     <= '0;
      end else begin
         r_mode    <= w_mode_nxt;
         r_idx     <= w_idx_nxt;
         r_pre_cnt <= w_pre_nxt;
         r_led     <= pattern(r_mode, r_idx);
      end
   end

   assign led_out = r_led;
   assign mode    = r_mode;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random key/enable/reset
// traffic, compared every cycle against an elapsed-time reference model.
module tb_led_pattern_ctrl;

   localparam int unsigned CLK_FREQ = 10;
   localparam int unsigned STEP_HZ  = 1;
   localparam int unsigned DEB_CYC  = 3;
   localparam int          STEP_CYC = 10;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       key_n;
   logic       en;
   logic [3:0] led_out;
   logic [1:0] mode;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 sys_clk = ~sys_clk;

   led_pattern_ctrl #(
      .CLK_FREQ (CLK_FREQ),
      .STEP_HZ  (STEP_HZ),
      .DEB_CYC  (DEB_CYC)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_n     (key_n),
      .en        (en),
      .led_out   (led_out),
      .mode      (mode)
   );

   // Reference model: the step index is derived from the number of enabled
   // cycles since the last mode change; the key path from sample history.
   int         m_mode;
   int         m_en_cycles;
   bit         m_key_st;
   bit         m_hist[$];
   bit         m_win[$];
   logic [3:0] m_led;
   int         period[4]      = '{2, 4, 6, 16};
   int         bounce_seq[6]  = '{1, 2, 4, 8, 4, 2};

   function automatic int cur_idx();
      return (m_en_cycles / STEP_CYC) % period[m_mode];
   endfunction

   function automatic logic [3:0] pat(int md, int ix);
      case (md)
         0:       return (ix == 0) ? 4'b0000 : 4'b1111;
         1:       return 4'(1 << ix);
         2:       return 4'(bounce_seq[ix]);
         default: return 4'(ix);
      endcase
   endfunction

   function automatic void model_edge(bit r, bit e, bit k);
      bit         seen;
      bit         all_diff;
      logic [3:0] led_next;
      if (!r) begin
         m_led       = 4'b0000;
         m_mode      = 0;
         m_en_cycles = 0;
         m_key_st    = 1'b1;
         m_hist      = '{1'b1, 1'b1};
         m_win.delete();
         return;
      end
      led_next = pat(m_mode, cur_idx());
      seen = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(k);
      m_win.push_back(seen);
      if (m_win.size() > DEB_CYC) void'(m_win.pop_front());
      all_diff = (m_win.size() == DEB_CYC);
      foreach (m_win[i]) if (m_win[i] == m_key_st) all_diff = 1'b0;
      if (all_diff) begin
         m_key_st = seen;
         if (seen == 1'b0) begin
            m_mode      = (m_mode + 1) % 4;
            m_en_cycles = 0;
         end else if (e) begin
            m_en_cycles++;
         end
      end else if (e) begin
         m_en_cycles++;
      end
      m_led = led_next;
   endfunction

   task automatic check(string tag, logic [3:0] got, logic [3:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
   endtask

   // Drive at the falling edge, model at the rising edge, sample at the next falling edge.
   task automatic cycle(bit r, bit e, bit k);
      sys_rst_n = r;
      en        = e;
      key_n     = k;
      @(posedge sys_clk);
      model_edge(r, e, k);
      @(negedge sys_clk);
      check("led_out", led_out, m_led);
      check("mode", {2'b00, mode}, 4'(m_mode));
   endtask

   task automatic key_pulse(int low, int high, bit e);
      for (int i = 0; i < low; i++)  cycle(1'b1, e, 1'b0);
      for (int i = 0; i < high; i++) cycle(1'b1, e, 1'b1);
   endtask

   initial begin
      bit kval;
      int krem;
      bit found;
      sys_rst_n = 1'b0;
      en        = 1'b1;
      key_n     = 1'b1;
      @(negedge sys_clk);

      // Reset, then plain BLINK timing.
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, 1'b1);

      // Long press -> CHASE; short glitch ignored; exact-length pulse accepted.
      key_pulse(10, 30, 1'b1);
      key_pulse(2, 20, 1'b1);
      key_pulse(3, 20, 1'b1);

      // BOUNCE full sequence, then on to BINARY.
      for (int i = 0; i < 70; i++) cycle(1'b1, 1'b1, 1'b1);
      key_pulse(5, 40, 1'b1);

      // Freeze for 25 cycles with the prescaler at 4, then resume.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_en_cycles % STEP_CYC == 4) found = 1'b1;
         else cycle(1'b1, 1'b1, 1'b1);
      end
      check("wait_pre4", 4'(found), 4'd1);
      for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b1);

      // Land a press on the same edge as a step tick.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_en_cycles % STEP_CYC == 5) found = 1'b1;
         else cycle(1'b1, 1'b1, 1'b1);
      end
      check("wait_tick_align", 4'(found), 4'd1);
      key_pulse(6, 30, 1'b1);

      // Back into BINARY, reach idx 9, then a one-cycle reset.
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (m_mode == 3) found = 1'b1;
         else key_pulse(5, 10, 1'b1);
      end
      check("reach_binary", 4'(found), 4'd1);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (m_mode == 3 && cur_idx() == 9) found = 1'b1;
         else cycle(1'b1, 1'b1, 1'b1);
      end
      check("wait_idx9", 4'(found), 4'd1);
      cycle(1'b1, 1'b1, 1'b1);
      check("binary_idx9_led", led_out, 4'b1001);
      cycle(1'b0, 1'b1, 1'b1);
      check("reset_led_zero", led_out, 4'b0000);
      for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, 1'b1);

      // Randomized traffic: bursty key levels, mostly-on enable, rare resets.
      kval = 1'b1;
      krem = 0;
      for (int i = 0; i < 3000; i++) begin
         if (krem == 0) begin
            kval = ~kval;
            krem = $urandom_range(1, 8);
         end
         krem--;
         cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) != 0), kval);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
